sa_seq_ctrl: RTL and testbench
==============================

SA_SEQ_CTRL -- requirements
Module: sa_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 4: systolic array dimension; legal range 2..16.
REQ-002 SHALL have parameter K_W, default 8: width of the inner-dimension length and the read address.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port i_start, input, 1: start request, sampled only in IDLE.
REQ-006 SHALL have port i_k_len, input, K_W: inner dimension K, latched with an accepted start.
REQ-007 SHALL have port i_abort, input, 1: synchronous abort, any state.
REQ-008 SHALL have port o_busy, output, 1: high in every state except IDLE.
REQ-009 SHALL have port o_acc_clr, output, 1: one-cycle accumulator-clear pulse to the array.
REQ-010 SHALL have port o_rd_en, output, 1: read strobe to the A-column and B-row operand buffers.
REQ-011 SHALL have port o_rd_addr, output, K_W: operand buffer read index k.
REQ-012 SHALL have port o_feed_vld, output, 1: valid for the operand data entering the skew shift registers; it is o_rd_en delayed one cycle, matching buffer read latency.
REQ-013 SHALL have port o_done, output, 1: one-cycle completion pulse.

Function
REQ-014 SHALL drive all outputs from flops; no combinational input-to-output paths.
REQ-015 SHALL implement the states IDLE, CLEAR, FEED, DRAIN and DONE.
REQ-016 IDLE: on i_start=1 and i_abort=0, SHALL latch i_k_len; go to CLEAR if K>0, else to DONE.
REQ-017 CLEAR: SHALL last 1 cycle with o_acc_clr=1, then go to FEED.
REQ-018 FEED: SHALL last exactly K cycles with o_rd_en=1 and o_rd_addr=0,1,...,K-1; go to DRAIN after the cycle with address K-1; o_rd_addr SHALL never wrap.
REQ-019 DRAIN: SHALL last exactly 2*N cycles (skew plus array propagation) with o_rd_en=0, then go to DONE.
REQ-020 DONE: SHALL last 1 cycle with o_done=1 and o_busy=1, then go to IDLE.
REQ-021 Timing for a start accepted at edge t0: o_acc_clr at t0+1; o_rd_en at t0+2..t0+1+K; o_feed_vld at t0+3..t0+2+K; o_done at t0+2+K+2N; o_busy at t0+1..t0+2+K+2N.
REQ-022 For K=0: o_done and o_busy SHALL be high at t0+1 only; there SHALL be no o_acc_clr, o_rd_en or o_feed_vld.
REQ-023 SHALL ignore i_start in every non-IDLE state, including DONE; it SHALL NOT change i_k_len capture or the timing.
REQ-024 i_abort=1 at any edge SHALL take the block to IDLE and zero all outputs on the following cycle, including o_feed_vld, with no o_done pulse.
REQ-025 i_abort SHALL take priority over i_start in the same cycle.
REQ-026 o_rd_addr SHALL be 0 whenever o_rd_en=0.
REQ-027 SHALL count the DRAIN period with a counter sized for 2*N; K=2^K_W-1 SHALL be supported without overflow.

Reset
REQ-028 While rst_n=0 at a rising edge, the state SHALL become IDLE and all outputs 0 on the next cycle, regardless of the current state.
REQ-029 Reset SHALL clear the latched K, the FEED and DRAIN counters and the o_feed_vld delay flop.
REQ-030 The first start SHALL be accepted in the first cycle with rst_n=1.

Verification (N=4)
REQ-031 Nominal: start with K=3 at cycle 0 -> clr at cycle 1; rd_en at cycles 2-4 with addr 0,1,2; feed_vld at cycles 3-5; done at cycle 13; busy at cycles 1-13.
REQ-032 Zero length: start with K=0 -> busy=done=1 at cycle 1 only; no clr, rd_en or feed_vld.
REQ-033 Ignored start: K=3 at cycle 0, then i_start held high through cycle 13 -> timing identical to REQ-031; next accepted start in IDLE at cycle 14 -> clr at cycle 15.
REQ-034 Abort: K=5 start at cycle 0, abort at cycle 4 (addr 2) -> all outputs 0 from cycle 5; no done; a new start at cycle 6 runs normally.
REQ-035 Reset mid-run: rst_n=0 during DRAIN -> outputs 0 next cycle; no done; the K=3 start after release reproduces REQ-031 timing.
REQ-036 Max length: K=255 -> addr 0..254 with no wrap; done at t0+265.

Source files
------------

// File: rtl/sa_seq_ctrl.sv
// Sequencer for an NxN systolic array: clears the accumulators, streams K
// operand reads into the skew registers, waits for the array to drain, then
// pulses done. Every output comes straight from a flop.
module sa_seq_ctrl #(
  parameter int N   = 4,
  parameter int K_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic [K_W-1:0] i_k_len,
  input  logic           i_abort,
  output logic           o_busy,
  output logic           o_acc_clr,
  output logic           o_rd_en,
  output logic [K_W-1:0] o_rd_addr,
  output logic           o_feed_vld,
  output logic           o_done
);

  // Drain covers the operand skew plus propagation across the array.
  localparam int             DW         = $clog2(2 * N);
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(2 * N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [K_W-1:0] r_k;
  logic [DW-1:0]  r_drain_cnt;
  logic           r_busy;
  logic           r_acc_clr;
  logic           r_rd_en;
  logic [K_W-1:0] r_rd_addr;
  logic           r_feed_vld;
  logic           r_done;

  // Address of the final read; K is nonzero whenever FEED is entered, so
  // this never underflows. The read address doubles as the FEED counter.
  logic [K_W-1:0] w_last_addr;
  assign w_last_addr = r_k - K_W'(1);

  // Single FSM with registered outputs; reset and abort share the zeroing path.
  always_ff @(posedge clk) begin
    if (!rst_n || i_abort) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_feed_vld  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Feed valid tracks the one-cycle operand buffer read latency.
      r_feed_vld <= r_rd_en;
      r_acc_clr  <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_k    <= i_k_len;
            r_busy <= 1'b1;
            if (i_k_len != '0) begin
              r_state   <= S_CLEAR;
              r_acc_clr <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          r_state   <= S_FEED;
          r_rd_en   <= 1'b1;
          r_rd_addr <= '0;
        end
        S_FEED: begin
          if (r_rd_addr == w_last_addr) begin
            r_state     <= S_DRAIN;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_drain_cnt <= '0;
          end else begin
            r_rd_addr <= r_rd_addr + K_W'(1);
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + DW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_acc_clr  = r_acc_clr;
  assign o_rd_en    = r_rd_en;
  assign o_rd_addr  = r_rd_addr;
  assign o_feed_vld = r_feed_vld;
  assign o_done     = r_done;

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Directed bench for sa_seq_ctrl (N=4, K_W=8). Outputs are sampled 1 time
// unit after each rising edge; cycle n is the period following edge n, with
// the start sampled at edge 0.
module tb_sa_seq_ctrl;

  localparam int N   = 4;
  localparam int K_W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_start;
  logic [K_W-1:0] i_k_len;
  logic           i_abort;
  logic           o_busy;
  logic           o_acc_clr;
  logic           o_rd_en;
  logic [K_W-1:0] o_rd_addr;
  logic           o_feed_vld;
  logic           o_done;

  int checks = 0;
  int errors = 0;

  sa_seq_ctrl #(.N(N), .K_W(K_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_k_len   (i_k_len),
    .i_abort   (i_abort),
    .o_busy    (o_busy),
    .o_acc_clr (o_acc_clr),
    .o_rd_en   (o_rd_en),
    .o_rd_addr (o_rd_addr),
    .o_feed_vld(o_feed_vld),
    .o_done    (o_done)
  );

  always #5 clk = ~clk;

  // {busy, acc_clr, rd_en, rd_addr[7:0], feed_vld, done}
  logic [12:0] w_obs;
  assign w_obs = {o_busy, o_acc_clr, o_rd_en, o_rd_addr, o_feed_vld, o_done};

  // Expected outputs n cycles after a start with length k accepted at edge 0.
  function automatic logic [12:0] exp_run(int k, int n);
    logic busy, clr, rd, fv, dn;
    logic [7:0] a;
    if (k == 0) begin
      busy = (n == 1);
      dn   = (n == 1);
      clr  = 1'b0;
      rd   = 1'b0;
      fv   = 1'b0;
    end else begin
      busy = (n >= 1) && (n <= 2 + k + 2 * N);
      clr  = (n == 1);
      rd   = (n >= 2) && (n <= 1 + k);
      fv   = (n >= 3) && (n <= 2 + k);
      dn   = (n == 2 + k + 2 * N);
    end
    a = rd ? 8'(n - 2) : 8'd0;
    return {busy, clr, rd, a, fv, dn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_k_len = '0; i_abort = 1'b0;
    tick(); tick();
    checks++;
    if (w_obs !== 13'h0) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", w_obs, 13'h0);
    end
    // Start presented in the very first cycle with reset released.
    rst_n = 1'b1; i_start = 1'b1; i_k_len = 8'd3;
    for (int n = 1; n <= 16; n++) begin
      tick();
      i_start = 1'b0;
      checks++;
      if (w_obs !== exp_run(3, n)) begin
        errors++;
        $display("FAIL first_start cycle %0d got %h exp %h", n, w_obs, exp_run(3, n));
      end
    end
  endtask

  task automatic test_nominal();
    i_start = 1'b1; i_k_len = 8'd3;
    for (int n = 1; n <= 16; n++) begin
      tick();
      i_start = 1'b0;
      checks++;
      if (w_obs !== exp_run(3, n)) begin
        errors++;
        $display("FAIL nominal cycle %0d got %h exp %h", n, w_obs, exp_run(3, n));
      end
    end
  endtask

  task automatic test_zero_len();
    i_start = 1'b1; i_k_len = 8'd0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      i_start = 1'b0;
      checks++;
      if (w_obs !== exp_run(0, n)) begin
        errors++;
        $display("FAIL zero_len cycle %0d got %h exp %h", n, w_obs, exp_run(0, n));
      end
    end
  endtask

  // Start stays high through the whole run with a different length on the
  // bus; the second run (accepted at edge 14) must pick up length 7.
  task automatic test_ignored_start();
    i_start = 1'b1; i_k_len = 8'd3;
    for (int n = 1; n <= 14; n++) begin
      tick();
      i_k_len = 8'd7;
      checks++;
      if (w_obs !== exp_run(3, n)) begin
        errors++;
        $display("FAIL ignored_start cycle %0d got %h exp %h", n, w_obs, exp_run(3, n));
      end
    end
    for (int n = 15; n <= 14 + 20; n++) begin
      tick();
      i_start = 1'b0;
      checks++;
      if (w_obs !== exp_run(7, n - 14)) begin
        errors++;
        $display("FAIL restart_k7 cycle %0d got %h exp %h", n, w_obs, exp_run(7, n - 14));
      end
    end
  endtask

  task automatic test_abort();
    i_start = 1'b1; i_k_len = 8'd5;
    for (int n = 1; n <= 4; n++) begin
      tick();
      i_start = 1'b0;
      checks++;
      if (w_obs !== exp_run(5, n)) begin
        errors++;
        $display("FAIL abort_pre cycle %0d got %h exp %h", n, w_obs, exp_run(5, n));
      end
    end
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    checks++;
    if (w_obs !== 13'h0) begin
      errors++;
      $display("FAIL abort_zero cycle 5 got %h exp %h", w_obs, 13'h0);
    end
    tick();
    checks++;
    if (w_obs !== 13'h0) begin
      errors++;
      $display("FAIL abort_idle cycle 6 got %h exp %h", w_obs, 13'h0);
    end
    // Fresh start after the abort runs normally.
    i_start = 1'b1; i_k_len = 8'd2;
    for (int n = 1; n <= 14; n++) begin
      tick();
      i_start = 1'b0;
      checks++;
      if (w_obs !== exp_run(2, n)) begin
        errors++;
        $display("FAIL abort_restart cycle %0d got %h exp %h", n, w_obs, exp_run(2, n));
      end
    end
    // Abort wins over a simultaneous start in IDLE.
    i_start = 1'b1; i_abort = 1'b1; i_k_len = 8'd3;
    for (int n = 1; n <= 2; n++) begin
      tick();
      i_start = 1'b0; i_abort = 1'b0;
      checks++;
      if (w_obs !== 13'h0) begin
        errors++;
        $display("FAIL abort_priority cycle %0d got %h exp %h", n, w_obs, 13'h0);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    i_start = 1'b1; i_k_len = 8'd3;
    for (int n = 1; n <= 8; n++) begin
      tick();
      i_start = 1'b0;
      checks++;
      if (w_obs !== exp_run(3, n)) begin
        errors++;
        $display("FAIL rst_mid_pre cycle %0d got %h exp %h", n, w_obs, exp_run(3, n));
      end
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int n = 9; n <= 15; n++) begin
      checks++;
      if (w_obs !== 13'h0) begin
        errors++;
        $display("FAIL rst_mid_zero cycle %0d got %h exp %h", n, w_obs, 13'h0);
      end
      tick();
    end
    i_start = 1'b1; i_k_len = 8'd3;
    for (int n = 1; n <= 15; n++) begin
      tick();
      i_start = 1'b0;
      checks++;
      if (w_obs !== exp_run(3, n)) begin
        errors++;
        $display("FAIL rst_mid_restart cycle %0d got %h exp %h", n, w_obs, exp_run(3, n));
      end
    end
  endtask

  task automatic test_max_len();
    i_start = 1'b1; i_k_len = 8'd255;
    for (int n = 1; n <= 268; n++) begin
      tick();
      i_start = 1'b0;
      checks++;
      if (w_obs !== exp_run(255, n)) begin
        errors++;
        $display("FAIL max_len cycle %0d got %h exp %h", n, w_obs, exp_run(255, n));
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_len();
    test_ignored_start();
    test_abort();
    test_reset_mid_run();
    test_max_len();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
